// File: rtl/run_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : run_ctrl_if
// Purpose  : Request/status bundle between a run requester and run_ctrl.
//            master : requester side (drives go/abort/done_i, observes status)
//            slave  : run_ctrl side (samples requests, drives status)
// Signals  : go, abort, done_i          - requests and core completion flag
//            start_o, busy, finished,
//            timed_out, cycle_cnt[15:0] - controller status
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface run_ctrl_if;
    logic        go;
    logic        abort;
    logic        done_i;
    logic        start_o;
    logic        busy;
    logic        finished;
    logic        timed_out;
    logic [15:0] cycle_cnt;

    modport master (
        output go, abort, done_i,
        input  start_o, busy, finished, timed_out, cycle_cnt
    );

    modport slave (
        input  go, abort, done_i,
        output start_o, busy, finished, timed_out, cycle_cnt
    );
endinterface

`default_nettype wire

// File: rtl/run_ctrl.sv
//------------------------------------------------------------------------------
// Module   : run_ctrl
// Purpose  : Sequences a core through start (held in reset), run and
//            completion, counting RUN cycles with an optional watchdog.
// Ports    : clk            - clock, rising edge active
//            rst_n          - asynchronous active-low reset
//            bus (slave)    - go/abort/done_i in; start_o/busy/finished/
//                             timed_out/cycle_cnt out
// Params   : START_CYCLES   - cycles start_o is held high in START (1..15)
//            TIMEOUT        - RUN cycle limit for the watchdog (1..65534)
// Macro    : RUN_CTRL_TIMEOUT_EN - when defined, compiles in the watchdog
//            and the TOUT state; otherwise timed_out is tied low.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module run_ctrl #(
    parameter int          START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'd4000
) (
    input  wire        clk,
    input  wire        rst_n,
    run_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3
`ifdef RUN_CTRL_TIMEOUT_EN
        , S_TOUT = 3'd4
`endif
    } state_t;

    localparam logic [3:0] c_START_LAST = 4'(START_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_scnt;
    logic [3:0]  w_scnt_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic [15:0] w_cnt_inc;

    // Saturating RUN-cycle increment.
    assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : (r_cnt + 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_scnt  <= 4'd0;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_scnt  <= w_scnt_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_scnt_next  = r_scnt;
        w_cnt_next   = r_cnt;

        // abort overrides everything; the count of the abandoned run is kept.
        if (bus.abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE
`ifdef RUN_CTRL_TIMEOUT_EN
                , S_TOUT
`endif
                : begin
                    if (bus.go) begin
                        w_state_next = S_START;
                        w_scnt_next  = 4'd0;
                        w_cnt_next   = 16'd0;
                    end
                end
                S_START: begin
                    if (r_scnt == c_START_LAST) begin
                        w_state_next = S_RUN;
                    end else begin
                        w_scnt_next = r_scnt + 4'd1;
                    end
                end
                S_RUN: begin
                    // Completion is checked first so it wins over the watchdog;
                    // the completing cycle still counts as a RUN cycle.
                    if (bus.done_i) begin
                        w_state_next = S_DONE;
                        w_cnt_next   = w_cnt_inc;
`ifdef RUN_CTRL_TIMEOUT_EN
                    end else if (r_cnt == TIMEOUT) begin
                        w_state_next = S_TOUT;
`endif
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Status is decoded from the state register only.
    assign bus.start_o   = (r_state != S_RUN);
    assign bus.busy      = (r_state == S_START) || (r_state == S_RUN);
    assign bus.finished  = (r_state == S_DONE);
`ifdef RUN_CTRL_TIMEOUT_EN
    assign bus.timed_out = (r_state == S_TOUT);
`else
    assign bus.timed_out = 1'b0;
`endif
    assign bus.cycle_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_run_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_run_ctrl
// Purpose  : Directed self-checking bench for run_ctrl. Instance A uses the
//            default TIMEOUT, instance B uses TIMEOUT=20 for watchdog cases.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_run_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    run_ctrl_if ifa ();
    run_ctrl_if ifb ();

    run_ctrl #(.START_CYCLES(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    run_ctrl #(.START_CYCLES(2), .TIMEOUT(16'd20)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
        end else begin
            e = sbq.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    initial begin
        ifa.go = 1'b0; ifa.abort = 1'b0; ifa.done_i = 1'b0;
        ifb.go = 1'b0; ifb.abort = 1'b0; ifb.done_i = 1'b0;

        // Reset state
        #1;
        chk("rst_start_o", 32'(ifa.start_o), 32'd1);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_finished", 32'(ifa.finished), 32'd0);
        chk("rst_timed_out", 32'(ifa.timed_out), 32'd0);
        chk("rst_cnt", 32'(ifa.cycle_cnt), 32'd0);
        ticks(2);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(ifa.busy), 32'd0);

        // Run 1: done on the 110th RUN cycle
        ifa.go = 1'b1;
        sb_push("run1_cnt", 32'd110);
        tick();
        ifa.go = 1'b0;
        chk("run1_start1_start_o", 32'(ifa.start_o), 32'd1);
        chk("run1_start1_busy", 32'(ifa.busy), 32'd1);
        chk("run1_start_cnt0", 32'(ifa.cycle_cnt), 32'd0);
        tick();
        chk("run1_start2_start_o", 32'(ifa.start_o), 32'd1);
        tick();
        chk("run1_run_start_o", 32'(ifa.start_o), 32'd0);
        ticks(109);
        chk("run1_cnt109", 32'(ifa.cycle_cnt), 32'd109);
        ifa.done_i = 1'b1;
        tick();
        ifa.done_i = 1'b0;
        chk("run1_finished", 32'(ifa.finished), 32'd1);
        chk("run1_done_start_o", 32'(ifa.start_o), 32'd1);
        chk("run1_done_busy", 32'(ifa.busy), 32'd0);
        sb_check(32'(ifa.cycle_cnt));
        ticks(3);
        chk("run1_hold_cnt", 32'(ifa.cycle_cnt), 32'd110);
        chk("run1_hold_finished", 32'(ifa.finished), 32'd1);

        // Run 2 restarted from DONE, done on the 5th RUN cycle
        ifa.go = 1'b1;
        sb_push("run2_cnt", 32'd5);
        tick();
        ifa.go = 1'b0;
        chk("run2_restart_cnt0", 32'(ifa.cycle_cnt), 32'd0);
        chk("run2_restart_busy", 32'(ifa.busy), 32'd1);
        chk("run2_restart_finished", 32'(ifa.finished), 32'd0);
        ticks(2);
        ticks(4);
        ifa.done_i = 1'b1;
        tick();
        ifa.done_i = 1'b0;
        chk("run2_finished", 32'(ifa.finished), 32'd1);
        sb_check(32'(ifa.cycle_cnt));

        // abort from DONE keeps the count
        ifa.abort = 1'b1;
        tick();
        ifa.abort = 1'b0;
        chk("abort_done_finished", 32'(ifa.finished), 32'd0);
        chk("abort_done_cnt_hold", 32'(ifa.cycle_cnt), 32'd5);

        // done_i ignored in IDLE and START
        ifa.done_i = 1'b1;
        tick();
        chk("done_idle_ignored", 32'(ifa.finished), 32'd0);
        chk("done_idle_busy", 32'(ifa.busy), 32'd0);
        ifa.go = 1'b1;
        tick();
        ifa.go = 1'b0;
        chk("done_start1_ignored", 32'(ifa.finished), 32'd0);
        tick();
        chk("done_start2_ignored", 32'(ifa.finished), 32'd0);
        chk("done_start2_start_o", 32'(ifa.start_o), 32'd1);
        ifa.done_i = 1'b0;
        tick();
        chk("run3_in_run", 32'(ifa.start_o), 32'd0);
        ticks(3);
        chk("run3_cnt3", 32'(ifa.cycle_cnt), 32'd3);

        // abort and go together in RUN: abort wins
        ifa.abort = 1'b1;
        ifa.go    = 1'b1;
        tick();
        ifa.abort = 1'b0;
        ifa.go    = 1'b0;
        chk("abort_go_busy", 32'(ifa.busy), 32'd0);
        chk("abort_go_start_o", 32'(ifa.start_o), 32'd1);
        chk("abort_go_finished", 32'(ifa.finished), 32'd0);
        chk("abort_go_cnt_hold", 32'(ifa.cycle_cnt), 32'd3);
        tick();
        chk("abort_go_stays_idle", 32'(ifa.busy), 32'd0);

        // Asynchronous reset mid-RUN at cycle_cnt=37
        ifa.go = 1'b1;
        tick();
        ifa.go = 1'b0;
        ticks(2);
        ticks(37);
        chk("mid_run_cnt37", 32'(ifa.cycle_cnt), 32'd37);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", 32'(ifa.cycle_cnt), 32'd0);
        chk("async_rst_start_o", 32'(ifa.start_o), 32'd1);
        chk("async_rst_busy", 32'(ifa.busy), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("after_rst_idle", 32'(ifa.busy), 32'd0);
        chk("after_rst_cnt", 32'(ifa.cycle_cnt), 32'd0);

        // Instance B: watchdog with TIMEOUT=20, done_i held low
        ifb.go = 1'b1;
        tick();
        ifb.go = 1'b0;
        ticks(2);
        chk("b_in_run", 32'(ifb.start_o), 32'd0);
        ticks(20);
        chk("b_cnt20", 32'(ifb.cycle_cnt), 32'd20);
        chk("b_cnt20_busy", 32'(ifb.busy), 32'd1);
`ifdef RUN_CTRL_TIMEOUT_EN
        tick();
        chk("b_tout_timed_out", 32'(ifb.timed_out), 32'd1);
        chk("b_tout_busy", 32'(ifb.busy), 32'd0);
        chk("b_tout_cnt", 32'(ifb.cycle_cnt), 32'd20);
        chk("b_tout_start_o", 32'(ifb.start_o), 32'd1);
        ticks(3);
        chk("b_tout_hold_cnt", 32'(ifb.cycle_cnt), 32'd20);
        chk("b_tout_hold_flag", 32'(ifb.timed_out), 32'd1);
`else
        ticks(80);
        chk("b_nowd_busy", 32'(ifb.busy), 32'd1);
        chk("b_nowd_cnt100", 32'(ifb.cycle_cnt), 32'd100);
        chk("b_nowd_timed_out", 32'(ifb.timed_out), 32'd0);
`endif
        ifb.abort = 1'b1;
        tick();
        ifb.abort = 1'b0;
        chk("b_abort_idle", 32'(ifb.busy), 32'd0);

        // done_i exactly when cycle_cnt equals TIMEOUT: DONE wins
        ifb.go = 1'b1;
        sb_push("b_done_at_tout_cnt", 32'd21);
        tick();
        ifb.go = 1'b0;
        ticks(2);
        ticks(20);
        chk("b2_cnt20", 32'(ifb.cycle_cnt), 32'd20);
        ifb.done_i = 1'b1;
        tick();
        ifb.done_i = 1'b0;
        chk("b2_finished", 32'(ifb.finished), 32'd1);
        chk("b2_no_timeout", 32'(ifb.timed_out), 32'd0);
        sb_check(32'(ifb.cycle_cnt));

        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter START_CYCLES, default 2: number of cycles start_o is held high before a run begins (legal 1..15).
REQ-002 Parameter TIMEOUT, default 16'd4000: RUN-state cycle limit for the watchdog (legal 1..65534).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 go  input  1  run request, sampled each cycle.
REQ-006 abort  input  1  forces return to IDLE, sampled each cycle.
REQ-007 done_i  input  1  core completion flag (the core's done output).
REQ-008 start_o  output  1  drives the core's start/PC-reset input; high holds the core in reset.
REQ-009 busy  output  1  high in START and RUN.
REQ-010 finished  output  1  high in DONE.
REQ-011 timed_out  output  1  high in TOUT.
REQ-012 cycle_cnt  output  16  RUN-cycle count of the current or last run.

Function
REQ-013 States: IDLE, START, RUN, DONE, TOUT; all outputs registered or decoded from state only.
REQ-014 start_o is 1 in IDLE, START, DONE and TOUT, and 0 only in RUN.
REQ-015 IDLE/DONE/TOUT: go=1 -> START; the START-cycle counter and cycle_cnt load 0 on that edge.
REQ-016 START: stays exactly START_CYCLES cycles, then -> RUN; go is ignored.
REQ-017 RUN: cycle_cnt increments by 1 every RUN cycle, including the cycle in which done_i is seen, and saturates at 16'hFFFF.
REQ-018 RUN: done_i=1 -> DONE on the same edge; done_i is ignored in every state other than RUN.
REQ-019 RUN, TIMEOUT_EN builds: done_i=0 while cycle_cnt equals TIMEOUT -> TOUT, with cycle_cnt frozen at TIMEOUT.
REQ-020 RUN: go is ignored.
REQ-021 DONE/TOUT: state and cycle_cnt hold until go or abort.
REQ-022 abort=1 in any state -> IDLE next edge; cycle_cnt holds its value.
REQ-023 abort and go asserted in the same cycle: abort wins.
REQ-024 done_i=1 and the timeout condition in the same cycle: DONE wins.
REQ-025 A run in START or RUN when reset asserts is discarded; no partial result is retained.

Reset
REQ-026 reset=0 asynchronously forces IDLE, with start_o=1, busy=0, finished=0, timed_out=0 and cycle_cnt=0.
REQ-027 Leaving reset: the first state change occurs on the first rising clk edge after reset deasserts, as determined by go/abort.

Configuration
REQ-028 Macro RUN_CTRL_TIMEOUT_EN compiles the watchdog in or out.
REQ-029 Defined: REQ-019 applies and the TOUT state is reachable.
REQ-030 Undefined: RUN exits only on done_i or abort, timed_out is constant 0, the TOUT state is not implemented, and the TIMEOUT parameter is unused.

Verification
REQ-031 Reset then go pulse at cycle 0, START_CYCLES=2, done_i=1 on the 110th RUN cycle -> start_o high 2 cycles then low; finished=1 with cycle_cnt=110; start_o=1 in DONE.
REQ-032 TIMEOUT=20 with done_i held 0 (macro defined) -> timed_out=1 after 20 RUN cycles, cycle_cnt=20, busy=0; same stimulus with macro undefined -> still busy after 100 cycles with cycle_cnt=100.
REQ-033 done_i=1 during IDLE and START, and abort with go together in RUN -> no DONE entry; abort wins and the next state is IDLE.
REQ-034 done_i=1 on the cycle cycle_cnt=TIMEOUT=20 -> DONE, timed_out stays 0.
REQ-035 reset pulled low mid-RUN at cycle_cnt=37 -> immediate IDLE with cycle_cnt=0 and start_o=1 before the next clk edge.
REQ-036 go in DONE with cycle_cnt=110 -> START with cycle_cnt=0; the second run completes independently with its own count.
